// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search front end and the hex display controller.
package rc4_pkg;

  localparam int NUM_CORES = 4;
  localparam int KEY_W     = 24;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SEARCH,
    FOUND,
    FAILED
  } collector_state_t;

  localparam logic [NUM_CORES-1:0] SUCCESS_NONE = 4'b0000;

endpackage

// File: rtl/lowest_onehot.sv
// Priority encoder: keeps only the lowest set bit of the input (zero in gives zero out).
module lowest_onehot
  import rc4_pkg::*;
(
  input  logic [NUM_CORES-1:0] in,
  output logic [NUM_CORES-1:0] out
);

  // Two's complement isolates the lowest set bit.
  assign out = in & (~in + {{(NUM_CORES-1){1'b0}}, 1'b1});

endmodule

// File: rtl/crack_result_collector.sv
// Launches the four RC4 search cores, tracks their done/found flags, latches their keys
// and reports the first winner (lowest index on a tie) or an all-exhausted failure.
module crack_result_collector
  import rc4_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_found,
  input  logic [KEY_W-1:0]     core_key_0,
  input  logic [KEY_W-1:0]     core_key_1,
  input  logic [KEY_W-1:0]     core_key_2,
  input  logic [KEY_W-1:0]     core_key_3,
  output logic                 core_start,
  output logic                 core_stop,
  output logic [NUM_CORES-1:0] success_state,
  output logic [KEY_W-1:0]     secret_key_1,
  output logic [KEY_W-1:0]     secret_key_2,
  output logic [KEY_W-1:0]     secret_key_3,
  output logic [KEY_W-1:0]     secret_key_4,
  output logic                 busy,
  output logic                 failed
);

  collector_state_t state, state_nxt;

  logic [NUM_CORES-1:0] done_seen;
  logic [NUM_CORES-1:0] hit;
  logic [NUM_CORES-1:0] winner;
  logic                 all_done;
  logic [KEY_W-1:0]     core_key [NUM_CORES];
  logic [KEY_W-1:0]     key_q    [NUM_CORES];

  assign core_key[0] = core_key_0;
  assign core_key[1] = core_key_1;
  assign core_key[2] = core_key_2;
  assign core_key[3] = core_key_3;

  assign secret_key_1 = key_q[0];
  assign secret_key_2 = key_q[1];
  assign secret_key_3 = key_q[2];
  assign secret_key_4 = key_q[3];

  // found is only meaningful while the same core reports done
  assign hit      = core_done & core_found;
  assign all_done = &(done_seen | core_done);

  lowest_onehot u_winner (
    .in  (hit),
    .out (winner)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = LAUNCH;
      LAUNCH: state_nxt = SEARCH;
      SEARCH: begin
        if (hit != '0)    state_nxt = FOUND;
        else if (all_done) state_nxt = FAILED;
      end
      FOUND:  if (start) state_nxt = LAUNCH;
      FAILED: if (start) state_nxt = LAUNCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_start    <= 1'b0;
      core_stop     <= 1'b0;
      success_state <= SUCCESS_NONE;
      busy          <= 1'b0;
      failed        <= 1'b0;
      done_seen     <= '0;
      for (int i = 0; i < NUM_CORES; i++) key_q[i] <= '0;
    end else begin
      core_start <= (state_nxt == LAUNCH);
      busy       <= (state_nxt == LAUNCH) || (state_nxt == SEARCH);
      if (state_nxt == LAUNCH) begin
        core_stop     <= 1'b0;
        success_state <= SUCCESS_NONE;
        failed        <= 1'b0;
        done_seen     <= '0;
        for (int i = 0; i < NUM_CORES; i++) key_q[i] <= '0;
      end else if (state == SEARCH) begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (core_done[i] && !done_seen[i]) begin
            key_q[i]     <= core_key[i];
            done_seen[i] <= 1'b1;
          end
        end
        if (hit != '0) begin
          success_state <= winner;
          core_stop     <= 1'b1;
          // the winner's key is taken even if that core was already latched earlier
          for (int i = 0; i < NUM_CORES; i++) begin
            if (winner[i]) key_q[i] <= core_key[i];
          end
        end else if (all_done) begin
          failed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crack_result_collector.sv
// Directed bench for crack_result_collector with hand-computed expectations.
module tb_crack_result_collector;
  import rc4_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [3:0]       core_done;
  logic [3:0]       core_found;
  logic [KEY_W-1:0] core_key_0, core_key_1, core_key_2, core_key_3;
  logic             core_start, core_stop, busy, failed;
  logic [3:0]       success_state;
  logic [KEY_W-1:0] secret_key_1, secret_key_2, secret_key_3, secret_key_4;

  int checks   = 0;
  int failures = 0;

  crack_result_collector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .core_done     (core_done),
    .core_found    (core_found),
    .core_key_0    (core_key_0),
    .core_key_1    (core_key_1),
    .core_key_2    (core_key_2),
    .core_key_3    (core_key_3),
    .core_start    (core_start),
    .core_stop     (core_stop),
    .success_state (success_state),
    .secret_key_1  (secret_key_1),
    .secret_key_2  (secret_key_2),
    .secret_key_3  (secret_key_3),
    .secret_key_4  (secret_key_4),
    .busy          (busy),
    .failed        (failed)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle 1 time unit so outputs are sampled away from the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] ss,
                          input logic [KEY_W-1:0] k1, input logic [KEY_W-1:0] k2,
                          input logic [KEY_W-1:0] k3, input logic [KEY_W-1:0] k4,
                          input logic cs, input logic stop, input logic bz, input logic fl);
    checkOutput({tag, ".success"}, 32'(success_state), 32'(ss));
    checkOutput({tag, ".key1"},    32'(secret_key_1),  32'(k1));
    checkOutput({tag, ".key2"},    32'(secret_key_2),  32'(k2));
    checkOutput({tag, ".key3"},    32'(secret_key_3),  32'(k3));
    checkOutput({tag, ".key4"},    32'(secret_key_4),  32'(k4));
    checkOutput({tag, ".core_start"}, 32'(core_start), 32'(cs));
    checkOutput({tag, ".core_stop"},  32'(core_stop),  32'(stop));
    checkOutput({tag, ".busy"},       32'(busy),       32'(bz));
    checkOutput({tag, ".failed"},     32'(failed),     32'(fl));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; core_done = 4'h0; core_found = 4'h0;
    core_key_0 = '0; core_key_1 = '0; core_key_2 = '0; core_key_3 = '0;
    #1;
    applyStimulus();
    applyStimulus();
    checkAll("reset", 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) applyStimulus();
    checkAll("idle_hold", 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);

    // single hit from core 2
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkAll("t1_launch", 4'h0, 0, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus();
    checkAll("t1_search", 4'h0, 0, 0, 0, 0, 0, 0, 1, 0);
    core_done = 4'b0100; core_found = 4'b0100; core_key_2 = 24'd8;
    applyStimulus();
    checkAll("t1_found", 4'b0100, 0, 0, 24'd8, 0, 0, 1, 0, 0);
    core_done = 4'h0; core_found = 4'h0; core_key_2 = 24'd77;
    applyStimulus();
    checkAll("t1_hold", 4'b0100, 0, 0, 24'd8, 0, 0, 1, 0, 0);

    // simultaneous hits on cores 1 and 3: lowest index wins
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkAll("t2_launch_clear", 4'h0, 0, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus();
    core_done = 4'b1010; core_found = 4'b1010; core_key_1 = 24'd19; core_key_3 = 24'd15;
    applyStimulus();
    checkAll("t2_found", 4'b0010, 0, 24'd19, 0, 24'd15, 0, 1, 0, 0);

    // all cores exhaust on different cycles; a stray found without done is ignored
    core_done = 4'h0; core_found = 4'h0;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    applyStimulus();
    core_done = 4'b0001; core_key_0 = 24'd6; core_found = 4'b1000;
    applyStimulus();
    checkAll("t3_core0", 4'h0, 24'd6, 0, 0, 0, 0, 0, 1, 0);
    core_done = 4'b0011; core_key_0 = 24'd99; core_key_1 = 24'd19;
    applyStimulus();
    checkAll("t3_core1_latch_once", 4'h0, 24'd6, 24'd19, 0, 0, 0, 0, 1, 0);
    core_done = 4'b0111; core_key_2 = 24'd8;
    applyStimulus();
    checkAll("t3_core2", 4'h0, 24'd6, 24'd19, 24'd8, 0, 0, 0, 1, 0);
    core_done = 4'b1111; core_found = 4'h0; core_key_3 = 24'd15;
    applyStimulus();
    checkAll("t3_failed", 4'h0, 24'd6, 24'd19, 24'd8, 24'd15, 0, 0, 0, 1);

    // restart from FAILED, start ignored in SEARCH, tied hit 0/2 reports core 0
    core_done = 4'h0;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkAll("t4_launch_clear", 4'h0, 0, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus();
    checkAll("t4_search", 4'h0, 0, 0, 0, 0, 0, 0, 1, 0);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkAll("t4_start_ignored", 4'h0, 0, 0, 0, 0, 0, 0, 1, 0);
    core_done = 4'b0101; core_found = 4'b0101; core_key_0 = 24'd42; core_key_2 = 24'd3;
    applyStimulus();
    checkAll("t4_found", 4'b0001, 24'd42, 0, 24'd3, 0, 0, 1, 0, 0);

    // hit and last done together: success beats failure
    core_done = 4'h0; core_found = 4'h0;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    applyStimulus();
    core_done = 4'b0111; core_key_0 = 24'd1; core_key_1 = 24'd2; core_key_2 = 24'd4;
    applyStimulus();
    core_done = 4'b1111; core_found = 4'b1000; core_key_3 = 24'd5;
    applyStimulus();
    checkAll("t5_hit_beats_fail", 4'b1000, 24'd1, 24'd2, 24'd4, 24'd5, 0, 1, 0, 0);

    // reset mid-SEARCH while core 3 is hitting
    core_done = 4'h0; core_found = 4'h0;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    applyStimulus();
    core_done = 4'b1000; core_found = 4'b1000; core_key_3 = 24'd11;
    rst_n = 1'b0;
    applyStimulus();
    checkAll("t6_reset_mid_search", 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);

    // start coincident with reset: reset wins
    core_done = 4'h0; core_found = 4'h0;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkAll("t7_start_in_reset", 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus();
    checkAll("t7_idle_after", 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
